// File: rtl/irq_arbiter_if.sv
// Bundle for the interrupt request/acknowledge lines and the shared MCU byte channel
// between the sources/MCU side (master) and the arbiter (slave).
interface irq_arbiter_if #(
  parameter int unsigned NSRC = 4
) ();
  logic [NSRC-1:0] src_irq;
  logic [NSRC-1:0] src_iack;
  logic            mcu_irq;
  logic            data_in_strobe;
  logic            data_in_start;
  logic [7:0]      data_in;
  logic [7:0]      data_out;

  modport master (
    output src_irq,
    output data_in_strobe,
    output data_in_start,
    output data_in,
    input  src_iack,
    input  mcu_irq,
    input  data_out
  );

  modport slave (
    input  src_irq,
    input  data_in_strobe,
    input  data_in_start,
    input  data_in,
    output src_iack,
    output mcu_irq,
    output data_out
  );
endinterface

// File: rtl/irq_arbiter.sv
// Round-robin arbiter sharing one MCU interrupt line between NSRC level sources; the MCU
// reads the granted index over the byte channel and that read acknowledges the source.
module irq_arbiter #(
  parameter int unsigned NSRC    = 4,
  parameter int unsigned HOLDOFF = 16,
  parameter logic [7:0]  CMD     = 8'h05
) (
  input logic          clk,
  input logic          reset_n,
  irq_arbiter_if.slave bus
);

  localparam int unsigned    IdxW    = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [IdxW-1:0] LastRst = IdxW'(NSRC - 1);
  localparam logic [7:0]     HoldRst = 8'(HOLDOFF);

  typedef enum logic [1:0] {
    StIdle,
    StWaitAck,
    StHoldoff
  } state_e;

  state_e          r_state, w_state_d;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_iack, w_iack_d;
  logic [IdxW-1:0] r_grant, w_grant_d;
  logic [IdxW-1:0] r_last, w_last_d;
  logic [7:0]      r_hold_cnt, w_hold_cnt_d;
  logic            r_mcu_irq, w_mcu_irq_d;
  logic            r_ack_evt, w_ack_evt;

  logic            r_cmd_hit;
  logic [3:0]      r_byte_idx;
  logic [7:0]      r_data_out;

  logic [IdxW-1:0] w_cand, w_idx;
  logic            w_found;
  logic [2:0]      w_grant3;
  logic [7:0]      w_pend8, w_status;

  // Search starts just after the last acknowledged source and wraps back to it.
  always_comb begin
    w_cand  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 1; i <= NSRC; i++) begin
      w_idx = IdxW'((32'(r_last) + i) % NSRC);
      if (!w_found && r_pend[w_idx]) begin
        w_cand  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_pend8               = '0;
    w_pend8[NSRC-1:0]     = r_pend;
    w_grant3              = 3'(r_grant);
    w_status              = (r_state == StWaitAck) ? {1'b1, 4'b0000, w_grant3} : 8'h00;
  end

  // The pend-byte read of a hit command is the acknowledge, but only while a grant is live.
  assign w_ack_evt = bus.data_in_strobe && !bus.data_in_start && r_cmd_hit &&
                     (r_byte_idx == 4'd0) && (r_state == StWaitAck);

  always_comb begin
    w_state_d    = r_state;
    w_grant_d    = r_grant;
    w_last_d     = r_last;
    w_hold_cnt_d = r_hold_cnt;
    w_mcu_irq_d  = r_mcu_irq;
    w_iack_d     = '0;
    unique case (r_state)
      StIdle: begin
        w_mcu_irq_d = 1'b0;
        if (|r_pend) begin
          w_grant_d   = w_cand;
          w_mcu_irq_d = 1'b1;
          w_state_d   = StWaitAck;
        end
      end
      StWaitAck: begin
        w_mcu_irq_d = 1'b1;
        if (r_ack_evt) begin
          w_iack_d     = NSRC'(1) << r_grant;
          w_mcu_irq_d  = 1'b0;
          w_last_d     = r_grant;
          w_hold_cnt_d = HoldRst;
          w_state_d    = StHoldoff;
        end else if (!w_ack_evt && !r_pend[r_grant]) begin
          // Withdrawal; an ack arriving in the same cycle takes precedence.
          w_mcu_irq_d  = 1'b0;
          w_hold_cnt_d = HoldRst;
          w_state_d    = StHoldoff;
        end
      end
      StHoldoff: begin
        w_mcu_irq_d  = 1'b0;
        w_hold_cnt_d = r_hold_cnt - 8'd1;
        if (r_hold_cnt == 8'd1) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_mcu_irq_d = 1'b0;
        w_state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_pend     <= '0;
      r_iack     <= '0;
      r_grant    <= '0;
      r_last     <= LastRst;
      r_hold_cnt <= '0;
      r_mcu_irq  <= 1'b0;
      r_ack_evt  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pend     <= bus.src_irq;
      r_iack     <= w_iack_d;
      r_grant    <= w_grant_d;
      r_last     <= w_last_d;
      r_hold_cnt <= w_hold_cnt_d;
      r_mcu_irq  <= w_mcu_irq_d;
      r_ack_evt  <= w_ack_evt;
    end
  end

  // Replies only for our own command so other slaves on the channel keep data_out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_hit  <= 1'b0;
      r_byte_idx <= '0;
      r_data_out <= '0;
    end else if (bus.data_in_strobe) begin
      if (bus.data_in_start) begin
        r_cmd_hit  <= (bus.data_in == CMD);
        r_byte_idx <= '0;
        if (bus.data_in == CMD) begin
          r_data_out <= w_status;
        end
      end else if (r_cmd_hit) begin
        r_data_out <= (r_byte_idx == 4'd0) ? w_pend8 : 8'h00;
        if (r_byte_idx != 4'd15) begin
          r_byte_idx <= r_byte_idx + 4'd1;
        end
      end
    end
  end

  assign bus.src_iack = r_iack;
  assign bus.mcu_irq  = r_mcu_irq;
  assign bus.data_out = r_data_out;

endmodule
